// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and constants for the front-end pipeline control slice.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [15:0] RESET_PC  = 16'd8;

endpackage

// File: rtl/fe_hazard_detect.sv
// Load-use hazard compare between the ID source registers and the EX load destination.
module fe_hazard_detect #(
  parameter int NREG_W = 3
) (
  input  logic [NREG_W-1:0] id_rs_a,
  input  logic [NREG_W-1:0] id_rs_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              ex_is_load,
  input  logic [NREG_W-1:0] ex_rd,
  output logic              hazard
);

  // r0 is hard-wired zero, so a load targeting it never creates a dependency
  assign hazard = ex_is_load && (ex_rd != '0) &&
                  ((id_use_a && (id_rs_a == ex_rd)) || (id_use_b && (id_rs_b == ex_rd)));

endmodule

// File: rtl/fe_pipe_ctrl.sv
// Fetch-stage sequencer: branch redirect/squash, load-use stall, memory-wait freeze.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module fe_pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_LAT     = 1,
  parameter int NREG_W       = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [NREG_W-1:0] id_rs_a,
  input  logic [NREG_W-1:0] id_rs_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              ex_is_load,
  input  logic [NREG_W-1:0] ex_rd,
  input  logic              ex_br_taken,
  input  logic [15:0]       ex_br_target,
  input  logic              mem_busy,
  output logic              STALL,
  output logic              BRANCH,
  output logic [15:0]       branch_instr_addr,
  output logic              id_squash,
  output logic              ex_bubble,
  output logic [1:0]        ctrl_state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] LU_INIT    = 3'(LOAD_LAT - 2);

  ctrl_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] target_q, target_d;
  logic        br_q, br_d;
  logic        hazard;
  logic        stall_c, branch_c, squash_c, bubble_c;

  fe_hazard_detect #(.NREG_W(NREG_W)) u_hazard (
    .id_rs_a    (id_rs_a),
    .id_rs_b    (id_rs_b),
    .id_use_a   (id_use_a),
    .id_use_b   (id_use_b),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .hazard     (hazard)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      target_q <= '0;
      br_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      br_q     <= br_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    br_d     = br_q;
    stall_c  = 1'b0;
    branch_c = 1'b0;
    bubble_c = 1'b0;
    squash_c = (state_q == FLUSH);
    if (mem_busy) begin
      // whole pipe frozen; a pending redirect pulse is held until the wait ends
      stall_c = 1'b1;
    end else begin
      branch_c = br_q;
      br_d     = 1'b0;
      if (ex_br_taken) begin
        squash_c = 1'b1;
        bubble_c = 1'b1;
        target_d = ex_br_target;
        br_d     = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_INIT;
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end else begin
        case (state_q)
          FLUSH: begin
            bubble_c = 1'b1;
            if (cnt_q <= 3'd1) begin
              state_d = RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
          LU_STALL: begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            if (cnt_q == 3'd0) begin
              state_d = RUN;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
          RUN: begin
            // no stall on the redirect cycle: STALL and BRANCH are mutually exclusive
            if (hazard && !br_q) begin
              stall_c  = 1'b1;
              bubble_c = 1'b1;
              if (LOAD_LAT > 1) begin
                state_d = LU_STALL;
                cnt_d   = LU_INIT;
              end
            end
          end
          default: begin
            state_d = RUN;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // outputs forced low the moment reset rises, not just after the next edge
  assign STALL             = stall_c  & ~reset;
  assign BRANCH            = branch_c & ~reset;
  assign id_squash         = squash_c & ~reset;
  assign ex_bubble         = bubble_c & ~reset;
  assign branch_instr_addr = target_q;
  assign ctrl_state        = state_q;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_c && (perf_stall_cnt != 16'hFFFF)) perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (squash_c && (perf_flush_cnt != 16'hFFFF)) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fe_pipe_ctrl.sv
// Scoreboard bench for fe_pipe_ctrl: directed hazard/branch/mem-wait cases plus random traffic.
module tb_fe_pipe_ctrl;
  localparam int FC = 2;
  localparam int LL = 3;
  localparam int NW = 3;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic [NW-1:0] id_rs_a = '0, id_rs_b = '0, ex_rd = '0;
  logic          id_use_a = 1'b0, id_use_b = 1'b0, ex_is_load = 1'b0;
  logic          ex_br_taken = 1'b0, mem_busy = 1'b0;
  logic [15:0]   ex_br_target = '0;
  logic          STALL, BRANCH, id_squash, ex_bubble;
  logic [15:0]   branch_instr_addr;
  logic [1:0]    ctrl_state;
`ifdef PIPE_PERF_CNT_EN
  logic [15:0]   perf_stall_cnt, perf_flush_cnt;
`endif

  fe_pipe_ctrl #(.FLUSH_CYCLES(FC), .LOAD_LAT(LL), .NREG_W(NW)) dut (
    .CLOCK_50          (CLOCK_50),
    .reset             (reset),
    .id_rs_a           (id_rs_a),
    .id_rs_b           (id_rs_b),
    .id_use_a          (id_use_a),
    .id_use_b          (id_use_b),
    .ex_is_load        (ex_is_load),
    .ex_rd             (ex_rd),
    .ex_br_taken       (ex_br_taken),
    .ex_br_target      (ex_br_target),
    .mem_busy          (mem_busy),
    .STALL             (STALL),
    .BRANCH            (BRANCH),
    .branch_instr_addr (branch_instr_addr),
    .id_squash         (id_squash),
    .ex_bubble         (ex_bubble),
    .ctrl_state        (ctrl_state)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cnt    (perf_stall_cnt),
    .perf_flush_cnt    (perf_flush_cnt)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic        stall;
    logic        branch;
    logic        squash;
    logic        bubble;
    logic [15:0] addr;
    logic [1:0]  st;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // reference model: remaining squash cycles, remaining stall cycles, pending redirect
  int          sq_left = 0;
  int          st_left = 0;
  bit          br_pend = 0;
  logic [15:0] tgt = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sq_left = 0;
    st_left = 0;
    br_pend = 0;
    tgt     = '0;
  endtask

  task automatic drive(input logic mb, input logic bt, input logic [15:0] bta,
                       input logic ld, input logic [NW-1:0] rd, input logic [NW-1:0] ra,
                       input logic [NW-1:0] rb, input logic ua, input logic ub);
    exp_t e;
    bit   hz;
    @(posedge CLOCK_50);
    #1;
    mem_busy = mb; ex_br_taken = bt; ex_br_target = bta; ex_is_load = ld;
    ex_rd = rd; id_rs_a = ra; id_rs_b = rb; id_use_a = ua; id_use_b = ub;
    hz = ld && (rd != 0) && ((ua && ra == rd) || (ub && rb == rd));
    e.st     = (sq_left > 0) ? 2'd2 : (st_left > 0) ? 2'd1 : 2'd0;
    e.addr   = tgt;
    e.stall  = 0; e.branch = 0; e.bubble = 0;
    e.squash = (sq_left > 0);
    if (mb) begin
      e.stall = 1;
    end else begin
      e.branch = br_pend;
      br_pend  = 0;
      if (bt) begin
        e.squash = 1; e.bubble = 1;
        tgt = bta; br_pend = 1; sq_left = FC - 1; st_left = 0;
      end else if (sq_left > 0) begin
        e.bubble = 1; sq_left--;
      end else if (st_left > 0) begin
        e.stall = 1; e.bubble = 1; st_left--;
      end else if (hz && !e.branch) begin
        e.stall = 1; e.bubble = 1; st_left = LL - 1;
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 16'h0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge CLOCK_50) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("STALL", STALL, e.stall);
      chk("BRANCH", BRANCH, e.branch);
      chk("id_squash", id_squash, e.squash);
      chk("ex_bubble", ex_bubble, e.bubble);
      chk("ctrl_state", ctrl_state, e.st);
      if (e.branch) chk("branch_instr_addr", branch_instr_addr, e.addr);
    end
  end

  initial begin
    mem_busy = 1'b1;
    #3;
    chk("rst STALL", STALL, 0);
    chk("rst BRANCH", BRANCH, 0);
    chk("rst id_squash", id_squash, 0);
    chk("rst ex_bubble", ex_bubble, 0);
    chk("rst state", ctrl_state, 0);
    chk("rst target", branch_instr_addr, 0);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    mem_busy = 1'b0;
    model_reset();

    drive(0, 0, 16'h0, 1, 3, 3, 0, 1, 0);      // load r3, ID reads r3
    idle(LL + 1);
    drive(0, 0, 16'h0, 1, 0, 0, 0, 1, 1);      // load r0 never stalls
    idle(1);
    drive(0, 1, 16'h0040, 0, 0, 0, 0, 0, 0);   // taken branch
    idle(FC + 1);
    drive(0, 1, 16'h1234, 1, 5, 5, 5, 1, 1);   // branch beats hazard
    idle(FC + 1);
    drive(1, 1, 16'h0ABC, 0, 0, 0, 0, 0, 0);   // branch held by memory wait
    drive(1, 1, 16'h0ABC, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 16'h0ABC, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 16'h0ABC, 0, 0, 0, 0, 0, 0);
    idle(FC + 1);
    drive(0, 0, 16'h0, 1, 6, 1, 6, 0, 1);      // hazard then mem_busy inside LU_STALL
    drive(1, 0, 16'h0, 0, 0, 0, 0, 0, 0);
    idle(LL + 1);

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 8) == 0, ($urandom % 6) == 0, 16'($urandom),
            1'($urandom), NW'($urandom), NW'($urandom), NW'($urandom),
            1'($urandom), 1'($urandom));
    end
    idle(LL + FC);

    drive(0, 1, 16'h7777, 0, 0, 0, 0, 0, 0);   // reset in the flush window
    @(posedge CLOCK_50);
    #1;
    chk("pre-reset BRANCH", BRANCH, 1);
    chk("pre-reset id_squash", id_squash, 1);
    mem_busy = 1'b1;
    ex_br_taken = 1'b1;
    reset = 1'b1;
    #1;
    chk("async STALL", STALL, 0);
    chk("async BRANCH", BRANCH, 0);
    chk("async id_squash", id_squash, 0);
    chk("async ex_bubble", ex_bubble, 0);
    chk("async state", ctrl_state, 0);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    model_reset();
    idle(3);

`ifdef PIPE_PERF_CNT_EN
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1;
    chk("perf stall clr", perf_stall_cnt, 0);
    chk("perf flush clr", perf_flush_cnt, 0);
    @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    mem_busy = 1'b1;
    ex_br_taken = 1'b0;
    repeat (70000) @(posedge CLOCK_50);
    #1;
    chk("perf stall sat", perf_stall_cnt, 16'hFFFF);
    chk("perf flush idle", perf_flush_cnt, 0);
    mem_busy = 1'b0;
`endif

    repeat (2) @(negedge CLOCK_50);
    chk("scoreboard drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
